// File: rtl/button_event_arbiter.sv
// button_event_arbiter: turns press edges on four debounced buttons (N/E/S/W)
// into a 4-deep FIFO of 2-bit button codes. Buttons are granted round-robin.
// A press that cannot be recorded sets the sticky ovf flag.
// Optional feature macro: BTN_AUTOREPEAT_EN. When it is defined, a button that
// stays held injects synthetic presses: the first after HOLD_CYCLES, then one
// every REPEAT_CYCLES.
module button_event_arbiter #(
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_lvl,
  input  logic       ev_ready,
  input  logic       clr_ovf,
  output logic       ev_valid,
  output logic [1:0] ev_code,
  output logic [2:0] ev_count,
  output logic       ovf
);

  logic [3:0] prev;
  logic [3:0] pending;
  logic [1:0] last_grant;
  logic [1:0] fifo_mem [4];
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic [2:0] count;

  logic [3:0] real_press;
  logic [3:0] press;
  logic       rd_en;
  logic       grant_vld;
  logic [1:0] grant_idx;
  logic [1:0] cand;
  logic [3:0] grant_onehot;
  logic [3:0] drop;

  assign real_press = btn_lvl & ~prev;
  assign rd_en      = (count != 3'd0) & ev_ready;
  assign ev_valid   = (count != 3'd0);
  assign ev_code    = fifo_mem[rd_ptr];
  assign ev_count   = count;

`ifdef BTN_AUTOREPEAT_EN
  localparam int MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;

  logic [CW-1:0] hold_cnt [4];
  logic [3:0]    armed;
  logic [3:0]    in_repeat;
  logic [3:0]    syn_press;

  // A synthetic press fires when an armed, still-held button reaches its hold or repeat interval
  always_comb begin
    syn_press = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (armed[i] && btn_lvl[i]) begin
        if (in_repeat[i]) begin
          syn_press[i] = (hold_cnt[i] == CW'(REPEAT_CYCLES - 1));
        end else begin
          syn_press[i] = (hold_cnt[i] == CW'(HOLD_CYCLES - 1));
        end
      end
    end
  end

  // Per-button hold counters: armed by a real press, disarmed on release, restarted after each repeat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 4'b0000;
      in_repeat <= 4'b0000;
      for (int i = 0; i < 4; i++) hold_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (real_press[i]) begin
          hold_cnt[i]  <= '0;
          armed[i]     <= 1'b1;
          in_repeat[i] <= 1'b0;
        end else if (!btn_lvl[i]) begin
          hold_cnt[i]  <= '0;
          armed[i]     <= 1'b0;
          in_repeat[i] <= 1'b0;
        end else if (syn_press[i]) begin
          hold_cnt[i]  <= '0;
          in_repeat[i] <= 1'b1;
        end else if (armed[i]) begin
          hold_cnt[i]  <= hold_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press = real_press | syn_press;
`else
  logic unused_cfg;
  assign unused_cfg = HOLD_CYCLES[0] ^ REPEAT_CYCLES[0];
  assign press      = real_press;
`endif

  // Round-robin search from the button after the last grant; a full FIFO blocks any grant
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    if ((pending != 4'b0000) && (count != 3'd4)) begin
      for (int k = 1; k <= 4; k++) begin
        cand = last_grant + 2'(k);
        if (!grant_vld && pending[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  assign grant_onehot = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;
  assign drop         = press & pending & ~grant_onehot;

  // Edge detection, pending bits, grant pointer and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev       <= 4'b1111;
      pending    <= 4'b0000;
      last_grant <= 2'd3;
      ovf        <= 1'b0;
    end else begin
      prev    <= btn_lvl;
      pending <= (pending & ~grant_onehot) | press;
      if (grant_vld) begin
        last_grant <= grant_idx;
      end
      if (drop != 4'b0000) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  // Four-entry event FIFO; a write and a read in the same cycle leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= 2'd0;
    end else begin
      if (grant_vld) begin
        fifo_mem[wr_ptr] <= grant_idx;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      count <= count + {2'b00, grant_vld} - {2'b00, rd_en};
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Testbench for button_event_arbiter: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_button_event_arbiter;

  localparam int HOLD = 20;
  localparam int REP  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_lvl = 4'b0000;
  logic       ev_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_code;
  logic [2:0] ev_count;
  logic       ovf;

  int checks = 0;
  int passes = 0;

  // Reference model state
  bit [3:0] m_prev;
  bit [3:0] m_pend;
  int       m_last;
  bit       m_ovf;
  int       m_q[$];
  int       m_cycle = 0;
  bit [3:0] m_armed;
  int       m_tpress[4];

  wire [6:0] obs = {ev_valid, (ev_valid ? ev_code : 2'b00), ev_count, ovf};

  always #5 clk = ~clk;

  button_event_arbiter #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .rst_n(rst_n), .btn_lvl(btn_lvl), .ev_ready(ev_ready),
    .clr_ovf(clr_ovf), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_count(ev_count), .ovf(ovf)
  );

  function automatic logic [6:0] exp_vec();
    logic [1:0] c;
    c = (m_q.size() > 0) ? 2'(m_q[0]) : 2'b00;
    return {(m_q.size() > 0), c, 3'(m_q.size()), m_ovf};
  endfunction

  task automatic model_reset();
    m_prev  = 4'b1111;
    m_pend  = 4'b0000;
    m_last  = 3;
    m_ovf   = 1'b0;
    m_armed = 4'b0000;
    m_q.delete();
  endtask

  // One clock edge of the behavioural model, using the inputs currently driven
  task automatic model_step();
    bit [3:0] e;
    int g;
    bit dropped;
    bit real_e;
    bit syn_e;
    int d;
    e = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      real_e = btn_lvl[i] && !m_prev[i];
      syn_e = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      if (btn_lvl[i] && m_armed[i] && !real_e) begin
        d = m_cycle - m_tpress[i];
        if (d >= HOLD && ((d - HOLD) % REP) == 0) syn_e = 1'b1;
      end
`endif
      d = 0;
      if (real_e) begin
        m_armed[i] = 1'b1;
        m_tpress[i] = m_cycle;
      end else if (!btn_lvl[i]) begin
        m_armed[i] = 1'b0;
      end
      e[i] = real_e || syn_e;
    end
    g = -1;
    if (m_pend != 0 && m_q.size() < 4) begin
      for (int k = 1; k <= 4; k++) begin
        if (g < 0 && m_pend[(m_last + k) % 4]) g = (m_last + k) % 4;
      end
    end
    if (m_q.size() > 0 && ev_ready) void'(m_q.pop_front());
    dropped = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (e[i] && m_pend[i] && g != i) dropped = 1'b1;
    end
    if (g >= 0) begin
      m_q.push_back(g);
      m_pend[g] = 1'b0;
      m_last = g;
    end
    m_pend = m_pend | e;
    if (dropped) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    m_prev = btn_lvl;
    m_cycle++;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    btn_lvl = 4'b0000; ev_ready = 1'b0; clr_ovf = 1'b0;
    @(negedge clk);
    model_reset();
    checks++;
    if (obs !== 7'd0) $display("[TB] FAIL reset_outputs got=%b exp=%b", obs, 7'd0);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    // Queue some events, make ovf sticky, then reset asynchronously mid-cycle
    step();
    btn_lvl = 4'b1111;
    for (int n = 0; n < 6; n++) step();
    btn_lvl = 4'b0000; step();
    btn_lvl = 4'b0010; step();
    btn_lvl = 4'b0000; step();
    btn_lvl = 4'b0010; step();
    checks++;
    if (obs !== exp_vec()) $display("[TB] FAIL prereset_state got=%b exp=%b", obs, exp_vec());
    else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs !== 7'd0) $display("[TB] FAIL async_reset got=%b exp=%b", obs, 7'd0);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    btn_lvl = 4'b0000; ev_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      checks++;
      if (obs !== 7'd0) $display("[TB] FAIL post_reset_empty got=%b exp=%b", obs, 7'd0);
      else passes++;
    end
  endtask

  task automatic test_single_press();
    int first_valid;
    int valid_cycles;
    do_reset();
    btn_lvl = 4'b0000; ev_ready = 1'b1; clr_ovf = 1'b0;
    step();
    first_valid = -1;
    valid_cycles = 0;
    btn_lvl = 4'b0001;
    for (int n = 1; n <= 12; n++) begin
      if (n == 11) btn_lvl = 4'b0000;
      step();
      if (ev_valid === 1'b1) begin
        valid_cycles++;
        if (first_valid < 0) first_valid = n;
      end
      checks++;
      if (obs !== exp_vec()) $display("[TB] FAIL single_model n=%0d got=%b exp=%b", n, obs, exp_vec());
      else passes++;
    end
    checks++;
    if (valid_cycles !== 1 || first_valid !== 2)
      $display("[TB] FAIL single_latency got cycles=%0d first=%0d exp cycles=1 first=2", valid_cycles, first_valid);
    else passes++;
  endtask

  task automatic test_fifo_full_ovf();
    int codes[$];
    int exp_codes[5] = '{0, 1, 2, 3, 1};
    do_reset();
    btn_lvl = 4'b0000; ev_ready = 1'b0; clr_ovf = 1'b0;
    step();
    btn_lvl = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      step();
      checks++;
      if (obs !== exp_vec()) $display("[TB] FAIL fill_model n=%0d got=%b exp=%b", n, obs, exp_vec());
      else passes++;
    end
    checks++;
    if (ev_count !== 3'd4 || ev_code !== 2'd0)
      $display("[TB] FAIL fill_full got count=%0d code=%0d exp count=4 code=0", ev_count, ev_code);
    else passes++;
    btn_lvl = 4'b1101; step();
    btn_lvl = 4'b1111; step();
    checks++;
    if (ovf !== 1'b0 || ev_count !== 3'd4)
      $display("[TB] FAIL east_pending got ovf=%b count=%0d exp ovf=0 count=4", ovf, ev_count);
    else passes++;
    btn_lvl = 4'b1101; step();
    btn_lvl = 4'b1111; step();
    checks++;
    if (ovf !== 1'b1) $display("[TB] FAIL east_drop_ovf got=%b exp=1", ovf);
    else passes++;
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b0) $display("[TB] FAIL clr_ovf got=%b exp=0", ovf);
    else passes++;
    ev_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (ev_valid === 1'b1) codes.push_back(int'(ev_code));
      step();
      checks++;
      if (obs !== exp_vec()) $display("[TB] FAIL drain_model n=%0d got=%b exp=%b", n, obs, exp_vec());
      else passes++;
    end
    checks++;
    if (codes.size() != 5) $display("[TB] FAIL drain_len got=%0d exp=5", codes.size());
    else begin
      passes++;
      for (int n = 0; n < 5; n++) begin
        checks++;
        if (codes[n] != exp_codes[n]) $display("[TB] FAIL drain_order[%0d] got=%0d exp=%0d", n, codes[n], exp_codes[n]);
        else passes++;
      end
    end
    btn_lvl = 4'b0000; step();
  endtask

  task automatic test_held_through_reset();
    int events;
    int code_seen;
    btn_lvl = 4'b0100; ev_ready = 1'b1; clr_ovf = 1'b0;
    do_reset();
    events = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (ev_valid === 1'b1) events++;
    end
    checks++;
    if (events != 0) $display("[TB] FAIL held_no_event got=%0d exp=0", events);
    else passes++;
    btn_lvl = 4'b0000; step();
    btn_lvl = 4'b0100;
    code_seen = -1;
    for (int n = 0; n < 5; n++) begin
      step();
      if (ev_valid === 1'b1) begin
        events++;
        code_seen = int'(ev_code);
      end
      checks++;
      if (obs !== exp_vec()) $display("[TB] FAIL repress_model n=%0d got=%b exp=%b", n, obs, exp_vec());
      else passes++;
    end
    checks++;
    if (events != 1 || code_seen != 2) $display("[TB] FAIL repress_event got events=%0d code=%0d exp events=1 code=2", events, code_seen);
    else passes++;
    btn_lvl = 4'b0000; step();
  endtask

`ifdef BTN_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int ev_steps[$];
    int offs[5] = '{0, 20, 28, 36, 44};
    do_reset();
    btn_lvl = 4'b0000; ev_ready = 1'b1; clr_ovf = 1'b0;
    step();
    btn_lvl = 4'b1000;
    for (int n = 1; n <= 50; n++) begin
      step();
      if (ev_valid === 1'b1 && ev_code === 2'd3) ev_steps.push_back(n);
      checks++;
      if (obs !== exp_vec()) $display("[TB] FAIL repeat_model n=%0d got=%b exp=%b", n, obs, exp_vec());
      else passes++;
    end
    btn_lvl = 4'b0000; step();
    checks++;
    if (ev_steps.size() != 5) $display("[TB] FAIL repeat_count got=%0d exp=5", ev_steps.size());
    else begin
      passes++;
      for (int n = 0; n < 5; n++) begin
        checks++;
        if (ev_steps[n] - ev_steps[0] != offs[n])
          $display("[TB] FAIL repeat_offset[%0d] got=%0d exp=%0d", n, ev_steps[n] - ev_steps[0], offs[n]);
        else passes++;
      end
    end
  endtask
`endif

  task automatic test_random();
    int ready_pct;
    int fails_here;
    do_reset();
    btn_lvl = 4'b0000; clr_ovf = 1'b0;
    ready_pct = 70;
    fails_here = 0;
    for (int n = 0; n < 2000; n++) begin
      if (n % 100 == 0) ready_pct = $urandom_range(0, 100);
      if (n % 700 == 699) do_reset();
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 5) == 0) btn_lvl[i] = ~btn_lvl[i];
      end
      ev_ready = ($urandom_range(0, 99) < ready_pct);
      clr_ovf = ($urandom_range(0, 19) == 0);
      step();
      checks++;
      if (obs !== exp_vec()) begin
        if (fails_here < 20) $display("[TB] FAIL random_model n=%0d got=%b exp=%b", n, obs, exp_vec());
        fails_here++;
      end else passes++;
    end
    clr_ovf = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_single_press();
    test_fifo_full_ovf();
    test_held_through_reset();
`ifdef BTN_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
